spi_xfer_ctrl: RTL

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: generates SCLK/CSn and the capture/shift strobes
// for external PISO/SIPO registers, for all four CPOL/CPHA modes.
module spi_xfer_ctrl #(
  parameter int WordLen = 8,
  parameter int ClkDiv  = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic Start,
  input  logic CPOL,
  input  logic CPHA,
  output logic SCLK,
  output logic CSn,
  output logic SCLKEdgeFlg,
  output logic ShiftFlg,
  output logic EnSIPO,
  output logic Busy,
  output logic Done
);

  localparam int DivW  = (ClkDiv > 2) ? $clog2(ClkDiv) : 1;
  localparam int EdgeW = $clog2(2 * WordLen + 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [EdgeW-1:0] edge_q, edge_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             sclk_q, sclk_d;
  logic             csn_q, csn_d;
  logic             done_q, done_d;
  logic             edge_flg, shift_flg;
  logic             div_term;
  logic             next_odd;
  logic             last_edge;

  assign div_term  = (div_q == DivW'(ClkDiv - 1));
  // edge_q counts completed edges, so the upcoming edge number is edge_q+1
  assign next_odd  = ~edge_q[0];
  assign last_edge = (edge_q == EdgeW'(2 * WordLen - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      csn_q   <= csn_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    csn_d     = csn_q;
    done_d    = 1'b0;
    edge_flg  = 1'b0;
    shift_flg = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = CPOL;
        csn_d  = 1'b1;
        if (Start) begin
          cpol_d  = CPOL;
          cpha_d  = CPHA;
          div_d   = '0;
          edge_d  = '0;
          csn_d   = 1'b0;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (div_term) begin
          div_d   = '0;
          state_d = XFER;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      XFER: begin
        if (div_term) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EdgeW'(1);
          // Strobes are asserted in the cycle whose closing clk edge toggles SCLK
          edge_flg  = cpha_q ? ~next_odd : next_odd;
          shift_flg = cpha_q ? next_odd : (~next_odd & ~last_edge);
          if (last_edge) state_d = TRAIL;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      TRAIL: begin
        if (div_term) begin
          div_d   = '0;
          csn_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign SCLK        = sclk_q;
  assign CSn         = csn_q;
  assign Done        = done_q;
  assign Busy        = (state_q != IDLE);
  assign EnSIPO      = (state_q != IDLE);
  assign SCLKEdgeFlg = edge_flg;
  assign ShiftFlg    = shift_flg;

endmodule
